pipe_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage Kabeta core. It drives the per-stage enables of the inter-stage enable registers (PC, IF/ID, ID/EX, EX/MA, MA/WB). It also drives the NOP-inject (flush) controls for the ID and EX pipeline registers. It resolves load-use interlocks, instruction/data memory wait states and control-flow redirects, and runs the post-reset pipeline-clear sequence, because the pipeline registers themselves have no reset.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/stall_timeout_cnt.sv | 29 ++
 rtl/pipe_stall_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and enable constants for the Kabeta pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWAIT = 2'd2
  } state_t;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MA = 3;
  localparam int STG_WB = 4;

  localparam logic [4:0] EN_ALL       = 5'b11111;
  localparam logic [4:0] EN_NONE      = 5'b00000;
  localparam logic [4:0] EN_HOLD_IF   = 5'b11110;
  localparam logic [4:0] EN_HOLD_IFID = 5'b11100;

  localparam int INIT_CYCLES = 3;

endpackage

// File: rtl/stall_timeout_cnt.sv
// rtl/stall_timeout_cnt.sv - consecutive data-stall counter that flags the force-release cycle
module stall_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Stall,
  output logic Expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] stall_cnt;

  assign Expire = Stall && (stall_cnt == LAST);

  // The expiring cycle clears the count, so it never wraps.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt <= '0;
    end else if (Stall && !Expire) begin
      stall_cnt <= stall_cnt + CW'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - 5-stage pipeline stall/flush sequencer with post-reset clear
// Optional data-memory stall timeout is enabled by defining PIPE_MEM_TIMEOUT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       LoadUse,
  input  logic       IMemReady,
  input  logic       DMemReq,
  input  logic       DMemReady,
  input  logic       Redirect,
  output logic [4:0] StageEn,
  output logic       FlushID,
  output logic       FlushEX,
  output logic       MemTimeout,
  output logic [1:0] State
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("pipe_stall_ctrl: TIMEOUT_CYCLES out of range");
  end

  state_t     state;
  state_t     state_next;
  logic [1:0] init_cnt;
  logic       mem_wait;
  logic       expire;
  logic       dstall;

  // INIT ignores every input, so the stall counter must not see memory waits then.
  assign mem_wait = (state != ST_INIT) && DMemReq && !DMemReady;

`ifdef PIPE_MEM_TIMEOUT_EN
  stall_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timeout_cnt (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Stall  (mem_wait),
    .Expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign dstall = mem_wait && !expire;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 2'd1;
      end else begin
        init_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    StageEn    = EN_ALL;
    FlushID    = 1'b0;
    FlushEX    = 1'b0;
    MemTimeout = 1'b0;
    case (state)
      ST_INIT: begin
        // Unreset pipeline registers are filled with NOPs until they reach WB.
        StageEn = EN_HOLD_IF;
        FlushID = 1'b1;
        FlushEX = 1'b1;
        if (init_cnt == 2'(INIT_CYCLES - 1)) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        MemTimeout = expire;
        if (dstall) begin
          StageEn    = EN_NONE;
          state_next = ST_DWAIT;
        end else begin
          state_next = ST_RUN;
          if (Redirect) begin
            FlushID = 1'b1;
            FlushEX = 1'b1;
          end else if (LoadUse) begin
            StageEn = EN_HOLD_IFID;
            FlushEX = 1'b1;
          end else if (!IMemReady) begin
            StageEn = EN_HOLD_IF;
            FlushID = 1'b1;
          end
        end
      end
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl (TIMEOUT_CYCLES=4)
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       LoadUse = 1'b0;
  logic       IMemReady = 1'b1;
  logic       DMemReq = 1'b0;
  logic       DMemReady = 1'b0;
  logic       Redirect = 1'b0;
  logic [4:0] StageEn;
  logic       FlushID;
  logic       FlushEX;
  logic       MemTimeout;
  logic [1:0] State;

  int tests = 0;
  int fails = 0;

  // Stimulus vector: {Redirect, LoadUse, IMemReady, DMemReq, DMemReady}
  localparam logic [4:0] I_IDLE = 5'b00100;
  localparam logic [4:0] I_LU   = 5'b01100;
  localparam logic [4:0] I_IMN  = 5'b00000;
  localparam logic [4:0] I_RD   = 5'b10100;
  localparam logic [4:0] I_ST   = 5'b00110;
  localparam logic [4:0] I_RDY  = 5'b00111;
  localparam logic [4:0] I_STRD = 5'b10110;
  localparam logic [4:0] I_ALL  = 5'b11111;

  // Expected vector: {StageEn, FlushID, FlushEX, MemTimeout, State}
  localparam logic [10:0] E_INIT    = {5'b11110, 3'b110, 2'd0};
  localparam logic [10:0] E_RUN     = {5'b11111, 3'b000, 2'd1};
  localparam logic [10:0] E_STALL_R = {5'b00000, 3'b000, 2'd1};
  localparam logic [10:0] E_STALL_W = {5'b00000, 3'b000, 2'd2};
  localparam logic [10:0] E_LU_R    = {5'b11100, 3'b010, 2'd1};
  localparam logic [10:0] E_IM_R    = {5'b11110, 3'b100, 2'd1};
  localparam logic [10:0] E_RD_R    = {5'b11111, 3'b110, 2'd1};
  localparam logic [10:0] E_REL_W   = {5'b11111, 3'b000, 2'd2};
  localparam logic [10:0] E_RDREL_W = {5'b11111, 3'b110, 2'd2};
  localparam logic [10:0] E_TO_W    = {5'b11111, 3'b001, 2'd2};

  logic [10:0] sb[$];

  pipe_stall_ctrl #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .LoadUse   (LoadUse),
    .IMemReady (IMemReady),
    .DMemReq   (DMemReq),
    .DMemReady (DMemReady),
    .Redirect  (Redirect),
    .StageEn   (StageEn),
    .FlushID   (FlushID),
    .FlushEX   (FlushEX),
    .MemTimeout(MemTimeout),
    .State     (State)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [4:0] v);
    {Redirect, LoadUse, IMemReady, DMemReq, DMemReady} = v;
  endtask

  task automatic test_reset();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
    drive(I_IDLE);
    sb.push_back(E_INIT);
    #2;
    exp_v = sb.pop_front();
    got = {StageEn, FlushID, FlushEX, MemTimeout, State};
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL reset_held: got %b expected %b", got, exp_v);
    end
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    si = '{I_IDLE, I_STRD, I_LU, I_IDLE};
    se = '{E_INIT, E_INIT, E_INIT, E_RUN};
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset_seq cycle %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_hazards();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
    si = '{I_LU, I_IDLE, I_IMN, I_RD, 5'b11100, 5'b01000, 5'b10111, I_IDLE};
    se = '{E_LU_R, E_RUN, E_IM_R, E_RD_R, E_RD_R, E_LU_R, E_RD_R, E_RUN};
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL hazards step %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_data_stall();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
    si = '{I_ST, I_ST, I_ST, I_RDY, I_IDLE};
    se = '{E_STALL_R, E_STALL_W, E_STALL_W, E_REL_W, E_RUN};
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL data_stall step %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_priority();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
    si = '{I_STRD, I_STRD, I_ALL, I_IDLE};
    se = '{E_STALL_R, E_STALL_W, E_RDREL_W, E_RUN};
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL priority step %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_timeout();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
`ifdef PIPE_MEM_TIMEOUT_EN
    si = '{I_ST, I_ST, I_ST, I_ST, I_ST, I_RDY, I_IDLE};
    se = '{E_STALL_R, E_STALL_W, E_STALL_W, E_TO_W, E_STALL_R, E_REL_W, E_RUN};
`else
    si = '{I_ST, I_ST, I_ST, I_ST, I_ST, I_ST, I_ST, I_ST, I_RDY, I_IDLE};
    se = '{E_STALL_R, E_STALL_W, E_STALL_W, E_STALL_W, E_STALL_W,
           E_STALL_W, E_STALL_W, E_STALL_W, E_REL_W, E_RUN};
`endif
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL timeout step %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
    si = '{I_ST, I_ST, I_ST, I_RDY, I_ST, I_ST, I_ST, I_RDY, I_IDLE};
    se = '{E_STALL_R, E_STALL_W, E_STALL_W, E_REL_W,
           E_STALL_R, E_STALL_W, E_STALL_W, E_REL_W, E_RUN};
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset_in_dwait();
    logic [4:0]  si[$];
    logic [10:0] se[$];
    logic [10:0] got, exp_v;
    drive(I_ST);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    sb.push_back(E_STALL_W);
    exp_v = sb.pop_front();
    got = {StageEn, FlushID, FlushEX, MemTimeout, State};
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL reset_dwait_pre: got %b expected %b", got, exp_v);
    end
    Reset_n = 1'b0;
    sb.push_back(E_INIT);
    #1;
    exp_v = sb.pop_front();
    got = {StageEn, FlushID, FlushEX, MemTimeout, State};
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL reset_dwait_async: got %b expected %b", got, exp_v);
    end
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    si = '{I_ST, I_ST, I_ST, I_IDLE};
    se = '{E_INIT, E_INIT, E_INIT, E_RUN};
    for (int i = 0; i < si.size(); i++) begin
      drive(si[i]);
      sb.push_back(se[i]);
      @(negedge Clock);
      exp_v = sb.pop_front();
      got = {StageEn, FlushID, FlushEX, MemTimeout, State};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset_dwait_seq cycle %0d: got %b expected %b", i, got, exp_v);
      end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_hazards();
    test_data_stall();
    test_priority();
    test_timeout();
    test_back_to_back();
    test_reset_in_dwait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
